// File: rtl/inst_interchange_queue_pkg.sv
// Shared decode definitions: packed instruction-bundle field widths, offsets and total width.
// Every stage between the decoders and rename/dispatch imports these.
package decode_pkg;

    localparam int formatSize              = 4;
    localparam int opcodeSize              = 8;
    localparam int addressWidth            = 32;
    localparam int funcUnitCodeSize        = 4;
    localparam int instructionCounterWidth = 16;
    localparam int instMinIdWidth          = 4;
    localparam int PidSize                 = 8;
    localparam int TidSize                 = 8;
    localparam int regAccessPatternSize    = 12;
    localparam int bodySize                = 160;

    localparam int INST_W = formatSize + opcodeSize + addressWidth + funcUnitCodeSize
                          + instructionCounterWidth + instMinIdWidth + PidSize + TidSize
                          + regAccessPatternSize + bodySize;

    // Bit offsets of each field, LSB first.
    localparam int FORMAT_OFS     = 0;
    localparam int OPCODE_OFS     = FORMAT_OFS     + formatSize;
    localparam int ADDRESS_OFS    = OPCODE_OFS     + opcodeSize;
    localparam int FUNC_UNIT_OFS  = ADDRESS_OFS    + addressWidth;
    localparam int MAJ_ID_OFS     = FUNC_UNIT_OFS  + funcUnitCodeSize;
    localparam int MIN_ID_OFS     = MAJ_ID_OFS     + instructionCounterWidth;
    localparam int PID_OFS        = MIN_ID_OFS     + instMinIdWidth;
    localparam int TID_OFS        = PID_OFS        + PidSize;
    localparam int REG_ACCESS_OFS = TID_OFS        + TidSize;
    localparam int BODY_OFS       = REG_ACCESS_OFS + regAccessPatternSize;

    typedef struct packed {
        logic [bodySize-1:0]                body;
        logic [regAccessPatternSize-1:0]    reg_access;
        logic [TidSize-1:0]                 tid;
        logic [PidSize-1:0]                 pid;
        logic [instMinIdWidth-1:0]          min_id;
        logic [instructionCounterWidth-1:0] maj_id;
        logic [funcUnitCodeSize-1:0]        func_unit;
        logic [addressWidth-1:0]            address;
        logic [opcodeSize-1:0]              opcode;
        logic [formatSize-1:0]              format;
    } inst_bundle_t;

endpackage

// File: rtl/inst_interchange_queue_if.sv
// Decoder-side and dispatch-side handshake bundle of the instruction interchange queue.
// master drives instructions in and consumes them out; slave is the queue itself.
interface inst_interchange_queue_if
    import decode_pkg::*;
#(
    parameter int NUM_IN  = 4,
    parameter int NUM_OUT = 4,
    parameter int INST_W  = decode_pkg::INST_W,
    parameter int CNT_W   = 5
);

    logic                      flush_i;
    logic [NUM_IN-1:0]         enable_i;
    logic [NUM_IN*INST_W-1:0]  inst_i;
    logic                      stall_o;
    logic                      outStall_i;
    logic [NUM_OUT-1:0]        outEnable_o;
    logic [NUM_OUT*INST_W-1:0] inst_o;
    logic [CNT_W-1:0]          count_o;

    modport master (
        output flush_i, enable_i, inst_i, outStall_i,
        input  stall_o, outEnable_o, inst_o, count_o
    );

    modport slave (
        input  flush_i, enable_i, inst_i, outStall_i,
        output stall_o, outEnable_o, inst_o, count_o
    );

endinterface

// File: rtl/inst_interchange_queue_lane_compactor.sv
// Packs the payloads of enabled lanes towards lane 0, preserving lane order,
// and reports how many lanes were enabled.
module inst_lane_compactor
    import decode_pkg::*;
#(
    parameter int NUM_LANES = 4,
    parameter int LANE_W    = decode_pkg::INST_W,
    parameter int SUM_W     = $clog2(NUM_LANES + 1)
) (
    input  logic [NUM_LANES-1:0]        enable_i,
    input  logic [NUM_LANES*LANE_W-1:0] lanes_i,
    output logic [NUM_LANES*LANE_W-1:0] lanes_o,
    output logic [SUM_W-1:0]            valid_cnt_o
);

    logic [SUM_W-1:0] slot;

    // NOTE: every output gets a default before the loop, otherwise unwritten lanes infer latches.
    always_comb begin
        lanes_o = '0;
        slot    = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            if (enable_i[k]) begin
                lanes_o[int'(slot)*LANE_W +: LANE_W] = lanes_i[k*LANE_W +: LANE_W];
                slot = slot + SUM_W'(1);
            end
        end
        valid_cnt_o = slot;
    end

endmodule

// File: rtl/inst_interchange_queue.sv
// Circular instruction queue between decoders and rename/dispatch: compacts sparse input
// lanes, buffers DEPTH entries and emits up to NUM_OUT oldest per cycle through an output register.
module inst_interchange_queue
    import decode_pkg::*;
#(
    parameter int NUM_IN  = 4,
    parameter int NUM_OUT = 4,
    parameter int INST_W  = decode_pkg::INST_W,
    parameter int DEPTH   = 16,
    parameter int CNT_W   = $clog2(DEPTH) + 1
) (
    input logic                     clock_i,
    input logic                     reset_i,
    inst_interchange_queue_if.slave q_if
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int LCNT_W = $clog2(NUM_IN + 1);

    logic [INST_W-1:0]         mem_q [DEPTH];
    logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]          count_q, count_d;
    logic                      stall_q, stall_d;
    logic [NUM_OUT-1:0]        out_en_q, out_en_d;
    logic [NUM_OUT*INST_W-1:0] out_inst_q, out_inst_d;

    logic [NUM_IN*INST_W-1:0]  packed_inst;
    logic [LCNT_W-1:0]         in_cnt;
    logic                      accept, load;
    logic [CNT_W-1:0]          push_n, pop_n;

    inst_lane_compactor #(
        .NUM_LANES (NUM_IN),
        .LANE_W    (INST_W),
        .SUM_W     (LCNT_W)
    ) u_compactor (
        .enable_i    (q_if.enable_i),
        .lanes_i     (q_if.inst_i),
        .lanes_o     (packed_inst),
        .valid_cnt_o (in_cnt)
    );

    always_comb begin
        accept = !stall_q && !q_if.flush_i;
        load   = (!q_if.outStall_i || out_en_q == '0) && !q_if.flush_i;
        push_n = accept ? CNT_W'(in_cnt) : '0;
        pop_n  = '0;
        if (load) begin
            pop_n = (count_q > CNT_W'(NUM_OUT)) ? CNT_W'(NUM_OUT) : count_q;
        end

        count_d    = count_q + push_n - pop_n;
        wr_ptr_d   = wr_ptr_q + PTR_W'(push_n);
        rd_ptr_d   = rd_ptr_q + PTR_W'(pop_n);
        out_en_d   = out_en_q;
        out_inst_d = out_inst_q;

        if (load) begin
            out_en_d   = '0;
            out_inst_d = '0;
            for (int j = 0; j < NUM_OUT; j++) begin
                if (CNT_W'(j) < pop_n) begin
                    out_en_d[j]                    = 1'b1;
                    out_inst_d[j*INST_W +: INST_W] = mem_q[rd_ptr_q + PTR_W'(j)];
                end
            end
        end

        // Conservative: stall whenever a full-width write might not fit next cycle.
        stall_d = (CNT_W'(DEPTH) - count_d) < CNT_W'(NUM_IN);

        if (q_if.flush_i) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            out_en_d   = '0;
            out_inst_d = '0;
            stall_d    = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            stall_q    <= 1'b0;
            out_en_q   <= '0;
            out_inst_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            stall_q    <= stall_d;
            out_en_q   <= out_en_d;
            out_inst_q <= out_inst_d;
        end
    end

    // NOTE: storage is deliberately not reset; validity is tracked by the pointers and count alone.
    always_ff @(posedge clock_i) begin
        if (accept) begin
            for (int k = 0; k < NUM_IN; k++) begin
                if (LCNT_W'(k) < in_cnt) begin
                    mem_q[wr_ptr_q + PTR_W'(k)] <= packed_inst[k*INST_W +: INST_W];
                end
            end
        end
    end

    assign q_if.stall_o     = stall_q;
    assign q_if.outEnable_o = out_en_q;
    assign q_if.inst_o      = out_inst_q;
    assign q_if.count_o     = count_q;

endmodule

// File: tb/tb_inst_interchange_queue.sv
// Randomised and directed bench for inst_interchange_queue: a queue-level reference model
// tracks stored entries and output-register occupancy; a negedge monitor compares.
module tb_inst_interchange_queue;
    import decode_pkg::*;

    localparam int NI    = 4;
    localparam int NO    = 4;
    localparam int W     = decode_pkg::INST_W;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int MW    = instructionCounterWidth;

    typedef logic [W-1:0] inst_t;

    logic clock_i = 1'b0;
    logic reset_i = 1'b0;

    inst_interchange_queue_if #(.NUM_IN(NI), .NUM_OUT(NO), .INST_W(W), .CNT_W(CW)) q_if ();

    inst_interchange_queue #(
        .NUM_IN(NI), .NUM_OUT(NO), .INST_W(W), .DEPTH(DEPTH), .CNT_W(CW)
    ) dut (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .q_if    (q_if)
    );

    always #5 clock_i = ~clock_i;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input inst_t act, input inst_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic inst_t mk(input int maj);
        inst_t v;
        for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom;
        v[MAJ_ID_OFS +: MW] = MW'(maj);
        return v;
    endfunction

    // Reference model: buffered entries, output-register occupancy, and the
    // accept-ordered stream of instructions not yet consumed downstream.
    inst_t mq[$];
    inst_t pending[$];
    int    m_out_n = 0;
    bit    m_stall = 1'b0;
    int    m_n;

    always @(posedge clock_i or posedge reset_i) begin
        if (reset_i || q_if.flush_i) begin
            mq.delete();
            pending.delete();
            m_out_n = 0;
            m_stall = 1'b0;
        end else begin
            if (!q_if.outStall_i || m_out_n == 0) begin
                m_n = (mq.size() < NO) ? mq.size() : NO;
                for (int i = 0; i < m_n; i++) void'(mq.pop_front());
                m_out_n = m_n;
            end
            if (!m_stall) begin
                for (int k = 0; k < NI; k++) begin
                    if (q_if.enable_i[k]) begin
                        mq.push_back(q_if.inst_i[k*W +: W]);
                        pending.push_back(q_if.inst_i[k*W +: W]);
                    end
                end
            end
            m_stall = (DEPTH - mq.size()) < NI;
        end
    end

    bit    rand_phase = 1'b0;
    int    exp_maj    = 0;
    inst_t got_lane;

    always @(negedge clock_i) begin
        if (!reset_i) begin
            check("count_o", W'(q_if.count_o), W'(mq.size()));
            check("stall_o", W'(q_if.stall_o), W'(m_stall));
            check("outEnable_o", W'(q_if.outEnable_o), W'((1 << m_out_n) - 1));
            for (int j = 0; j < NO; j++) begin
                got_lane = q_if.inst_o[j*W +: W];
                if (j >= m_out_n) check($sformatf("idle_lane%0d", j), got_lane, '0);
                else if (j < pending.size()) check($sformatf("lane%0d", j), got_lane, pending[j]);
                else check("pending_underrun", W'(j), W'(pending.size()));
            end
            if (m_out_n > 0 && !q_if.outStall_i && !q_if.flush_i) begin
                for (int j = 0; j < m_out_n; j++) begin
                    if (pending.size() > 0) begin
                        if (rand_phase) begin
                            check("order_majID", W'(pending[0][MAJ_ID_OFS +: MW]), W'(exp_maj));
                            exp_maj++;
                        end
                        void'(pending.pop_front());
                    end
                end
            end
        end
    end

    int dir_id = 1000;

    task automatic tick();
        @(posedge clock_i);
        #1;
    endtask

    task automatic set_lanes(input logic [NI-1:0] en);
        q_if.enable_i = en;
        for (int k = 0; k < NI; k++) q_if.inst_i[k*W +: W] = mk(dir_id + k);
        dir_id += NI;
    endtask

    task automatic idle(input int n);
        q_if.enable_i   = '0;
        q_if.outStall_i = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_count"}, W'(q_if.count_o), '0);
        check({tag, "_stall"}, W'(q_if.stall_o), '0);
        check({tag, "_outEnable"}, W'(q_if.outEnable_o), '0);
        for (int j = 0; j < NO; j++) check({tag, "_inst"}, q_if.inst_o[j*W +: W], '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    inst_t a_inst, b_inst;
    int    fill_cnt[6]   = '{4, 4, 8, 12, 16, 16};
    bit    fill_stall[6] = '{0, 0, 0, 0, 1, 1};
    int    issued;
    int    budget;
    logic [NI-1:0] en;

    initial begin
        q_if.flush_i    = 1'b0;
        q_if.enable_i   = '0;
        q_if.inst_i     = '0;
        q_if.outStall_i = 1'b0;
        #1 reset_i = 1'b1;
        #2 check_zero_outputs("reset");
        #9 reset_i = 1'b0;
        tick();

        // Sparse lanes 1 and 3 compact to output lanes 0 and 1.
        a_inst = mk(500);
        b_inst = mk(501);
        set_lanes(4'b1010);
        q_if.inst_i[1*W +: W] = a_inst;
        q_if.inst_i[3*W +: W] = b_inst;
        tick();
        q_if.enable_i = '0;
        tick();
        check("sparse_outEnable", W'(q_if.outEnable_o), W'(4'b0011));
        check("sparse_lane0", q_if.inst_o[0 +: W], a_inst);
        check("sparse_lane1", q_if.inst_o[W +: W], b_inst);
        check("sparse_count", W'(q_if.count_o), '0);
        idle(2);

        // Fill until stalled with downstream blocked, then release.
        q_if.outStall_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            set_lanes(4'b1111);
            tick();
            check($sformatf("fill_count%0d", i), W'(q_if.count_o), W'(fill_cnt[i]));
            check($sformatf("fill_stall%0d", i), W'(q_if.stall_o), W'(fill_stall[i]));
        end
        q_if.enable_i   = '0;
        q_if.outStall_i = 1'b0;
        tick();
        check("release_count", W'(q_if.count_o), W'(12));
        check("release_stall", W'(q_if.stall_o), '0);
        idle(6);

        // Flush colliding with a full-width write at count 7.
        q_if.outStall_i = 1'b1;
        set_lanes(4'b1111); tick();
        set_lanes(4'b1111); tick();
        set_lanes(4'b0111); tick();
        check("preflush_count", W'(q_if.count_o), W'(7));
        set_lanes(4'b1111);
        q_if.flush_i = 1'b1;
        tick();
        q_if.flush_i  = 1'b0;
        q_if.enable_i = '0;
        check("flush_count", W'(q_if.count_o), '0);
        check("flush_outEnable", W'(q_if.outEnable_o), '0);
        check("flush_stall", W'(q_if.stall_o), '0);
        idle(3);

        // Simultaneous push and pop: 4 buffered, 3 written while 4 are loaded.
        q_if.outStall_i = 1'b1;
        set_lanes(4'b1111); tick();
        q_if.outStall_i = 1'b0;
        set_lanes(4'b0111); tick();
        check("pushpop_count", W'(q_if.count_o), W'(3));
        check("pushpop_outEnable", W'(q_if.outEnable_o), W'(4'b1111));
        idle(4);

        // Asynchronous reset mid-stream at count 9.
        q_if.outStall_i = 1'b1;
        set_lanes(4'b1111); tick();
        set_lanes(4'b1111); tick();
        set_lanes(4'b1111); tick();
        set_lanes(4'b0001); tick();
        check("prereset_count", W'(q_if.count_o), W'(9));
        set_lanes(4'b1111);
        q_if.outStall_i = 1'b0;
        #1 reset_i = 1'b1;
        #1 check_zero_outputs("midreset");
        #1 reset_i = 1'b0;
        @(posedge clock_i);
        #1;
        check("postreset_accept", W'(q_if.count_o), W'(4));
        idle(4);

        // Random stream of 200 sequential majIDs with random enables and backpressure.
        rand_phase = 1'b1;
        issued     = 0;
        budget     = 0;
        while (issued < 200 && budget < 5000) begin
            q_if.outStall_i = ($urandom_range(0, 9) < 4);
            en = NI'($urandom_range(0, (1 << NI) - 1));
            if (q_if.stall_o) begin
                q_if.enable_i = en;
                for (int k = 0; k < NI; k++) q_if.inst_i[k*W +: W] = mk(16'hFFFF);
            end else begin
                for (int k = 0; k < NI; k++) begin
                    if (en[k] && issued < 200) begin
                        q_if.inst_i[k*W +: W] = mk(issued);
                        issued++;
                    end else begin
                        en[k] = 1'b0;
                        q_if.inst_i[k*W +: W] = mk(16'hFFFF);
                    end
                end
                q_if.enable_i = en;
            end
            tick();
            budget++;
        end
        q_if.enable_i   = '0;
        q_if.outStall_i = 1'b0;
        budget = 0;
        while ((pending.size() != 0 || q_if.outEnable_o != '0) && budget < 200) begin
            tick();
            budget++;
        end
        check("random_issued", W'(issued), W'(200));
        check("random_drained", W'(pending.size()), '0);
        check("random_stream_len", W'(exp_maj), W'(200));
        rand_phase = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
